// File: rtl/adbg_core_dbg_unit_if.sv
// ---------------------------------------------------------------------------
// adbg_core_dbg_unit_if
// Debug-bus request/response bundle between a debug host (master) and the
// core debug unit (slave).
//   dbg_addr_i  [15:0]  word address
//   dbg_data_i  [31:0]  write data
//   dbg_data_o  [31:0]  read data, valid only while dbg_ack_o is high
//   dbg_stb_i           request strobe, held by the host until ack
//   dbg_we_i            1 = write
//   dbg_ack_o           one-cycle completion pulse
// ---------------------------------------------------------------------------
interface adbg_core_dbg_unit_if;
    logic [15:0] dbg_addr_i;
    logic [31:0] dbg_data_i;
    logic [31:0] dbg_data_o;
    logic        dbg_stb_i;
    logic        dbg_we_i;
    logic        dbg_ack_o;

    modport slave (
        input  dbg_addr_i,
        input  dbg_data_i,
        input  dbg_stb_i,
        input  dbg_we_i,
        output dbg_data_o,
        output dbg_ack_o
    );

    modport master (
        output dbg_addr_i,
        output dbg_data_i,
        output dbg_stb_i,
        output dbg_we_i,
        input  dbg_data_o,
        input  dbg_ack_o
    );
endinterface

// File: rtl/adbg_core_dbg_unit.sv
// ---------------------------------------------------------------------------
// adbg_core_dbg_unit
// Core debug unit: debug-bus register slave (CTRL, CAUSE, NPC, GPR window)
// plus breakpoint/step/host-halt control for one CPU core.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   dbg (slave modport)   debug-bus address/data/strobe/we/ack
//   dbg_stall_i           host halt request
//   dbg_bp_o              core stopped on its own (trap/step/hw-bp)
//   core_halt_req_o       registered halt request to the core
//   core_halted_i         core reports halted
//   core_trap_i           one-cycle pulse, trap executed
//   core_retire_i         one-cycle pulse, instruction retired
//   core_pc_i             current PC
//   core_npc_o/_we_o      new PC value and one-cycle write pulse
//   rf_req_o ... rf_gnt_i register-file access handshake (GPR window)
//
// Register map (word addresses)
//   0x0000 CTRL   bit0 STEP, bit1 ERR (sticky, write-1-clear), bit2 BPEN
//   0x0001 CAUSE  0 none, 1 trap, 2 step, 3 host, 4 hw-bp (read-only)
//   0x0002 NPC    read core_pc_i, write pulses core_npc_we_o
//   0x0003 BPADDR hardware breakpoint address
//   0x0400-0x041F GPR window (core must be halted)
//
// Build option: define ADBG_CORE_HW_BP_EN to include BPADDR, CTRL.BPEN and
// the PC comparator. Without it BPADDR and BPEN read 0 and ignore writes.
// ---------------------------------------------------------------------------
module adbg_core_dbg_unit (
    input  logic        clk_i,
    input  logic        rst_i,

    adbg_core_dbg_unit_if.slave dbg,

    input  logic        dbg_stall_i,
    output logic        dbg_bp_o,

    output logic        core_halt_req_o,
    input  logic        core_halted_i,
    input  logic        core_trap_i,
    input  logic        core_retire_i,
    input  logic [31:0] core_pc_i,
    output logic [31:0] core_npc_o,
    output logic        core_npc_we_o,

    output logic        rf_req_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_addr_o,
    output logic [31:0] rf_wdata_o,
    input  logic [31:0] rf_rdata_i,
    input  logic        rf_gnt_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEC     = 3'd1;
    localparam logic [2:0] S_RF      = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_WAITLOW = 3'd4;

    localparam logic [15:0] A_CTRL   = 16'h0000;
    localparam logic [15:0] A_CAUSE  = 16'h0001;
    localparam logic [15:0] A_NPC    = 16'h0002;
    localparam logic [15:0] A_BPADDR = 16'h0003;

    localparam logic [2:0] C_TRAP = 3'd1;
    localparam logic [2:0] C_STEP = 3'd2;
    localparam logic [2:0] C_HOST = 3'd3;
    localparam logic [2:0] C_HWBP = 3'd4;

    logic [2:0]  state_q;
    logic        step_q;
    logic        err_q;
    logic [2:0]  cause_q;
    logic        bp_latched_q;
    logic        stall_q;
    logic        halt_req_q;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic        npc_we_q;
    logic [31:0] npc_q;
    logic        rf_req_q;
    logic        rf_we_q;
    logic [4:0]  rf_addr_q;
    logic [31:0] rf_wdata_q;

    logic        is_gpr;
    logic        bpen;
    logic        hw_bp_hit;
    logic [31:0] bpaddr_rd;
    logic [31:0] reg_rdata;

    // 0x0400..0x041F: upper eleven address bits equal 0x020
    assign is_gpr = (dbg.dbg_addr_i[15:5] == 11'h020);

`ifdef ADBG_CORE_HW_BP_EN
    logic        bpen_q;
    logic [31:0] bpaddr_q;

    assign bpen      = bpen_q;
    assign bpaddr_rd = bpaddr_q;
    assign hw_bp_hit = bpen_q && (core_pc_i == bpaddr_q) && !core_halted_i && !dbg_stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bpen_q   <= 1'b0;
            bpaddr_q <= '0;
        end else if (state_q == S_DEC && !is_gpr && dbg.dbg_we_i) begin
            if (dbg.dbg_addr_i == A_CTRL)
                bpen_q <= dbg.dbg_data_i[2];
            if (dbg.dbg_addr_i == A_BPADDR)
                bpaddr_q <= dbg.dbg_data_i;
        end
    end
`else
    assign bpen      = 1'b0;
    assign bpaddr_rd = '0;
    assign hw_bp_hit = 1'b0;
`endif

    always_comb begin
        reg_rdata = '0;
        case (dbg.dbg_addr_i)
            A_CTRL:   reg_rdata = {29'b0, bpen, err_q, step_q};
            A_CAUSE:  reg_rdata = {29'b0, cause_q};
            A_NPC:    reg_rdata = core_pc_i;
            A_BPADDR: reg_rdata = bpaddr_rd;
            default:  reg_rdata = '0;
        endcase
    end

    // Bus FSM. ack/rdata/npc_we are one-cycle registered pulses that default
    // low every cycle and are only loaded on the transition into S_ACK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            npc_we_q   <= 1'b0;
            npc_q      <= '0;
            rf_req_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            npc_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dbg.dbg_stb_i)
                        state_q <= S_DEC;
                end
                S_DEC: begin
                    if (is_gpr && core_halted_i) begin
                        state_q    <= S_RF;
                        rf_req_q   <= 1'b1;
                        rf_we_q    <= dbg.dbg_we_i;
                        rf_addr_q  <= dbg.dbg_addr_i[4:0];
                        rf_wdata_q <= dbg.dbg_data_i;
                    end else if (is_gpr) begin
                        // core running: refuse the access, flag it, return 0
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        if (!dbg.dbg_we_i) begin
                            rdata_q <= reg_rdata;
                        end else if (dbg.dbg_addr_i == A_CTRL) begin
                            step_q <= dbg.dbg_data_i[0];
                            if (dbg.dbg_data_i[1])
                                err_q <= 1'b0;
                        end else if (dbg.dbg_addr_i == A_NPC) begin
                            npc_we_q <= 1'b1;
                            npc_q    <= dbg.dbg_data_i;
                        end
                    end
                end
                S_RF: begin
                    if (rf_gnt_i) begin
                        state_q    <= S_ACK;
                        ack_q      <= 1'b1;
                        if (!rf_we_q)
                            rdata_q <= rf_rdata_i;
                        rf_req_q   <= 1'b0;
                        rf_we_q    <= 1'b0;
                        rf_addr_q  <= '0;
                        rf_wdata_q <= '0;
                    end
                end
                S_ACK: begin
                    state_q <= S_WAITLOW;
                end
                S_WAITLOW: begin
                    // one access per strobe: wait for the host to drop it
                    if (!dbg.dbg_stb_i)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stop/halt control. Stall clears the latch and wins over any trap/step
    // in the same cycle; the first stop cause is kept until cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bp_latched_q <= 1'b0;
            cause_q      <= '0;
            stall_q      <= 1'b0;
            halt_req_q   <= 1'b0;
        end else begin
            stall_q    <= dbg_stall_i;
            halt_req_q <= dbg_stall_i | bp_latched_q;
            if (dbg_stall_i) begin
                bp_latched_q <= 1'b0;
                if (!stall_q && !bp_latched_q)
                    cause_q <= C_HOST;
            end else if (!bp_latched_q) begin
                if (core_trap_i) begin
                    bp_latched_q <= 1'b1;
                    cause_q      <= C_TRAP;
                end else if (hw_bp_hit) begin
                    bp_latched_q <= 1'b1;
                    cause_q      <= C_HWBP;
                end else if (core_retire_i && step_q) begin
                    bp_latched_q <= 1'b1;
                    cause_q      <= C_STEP;
                end
            end
        end
    end

    assign dbg.dbg_ack_o  = ack_q;
    assign dbg.dbg_data_o = rdata_q;
    assign dbg_bp_o       = bp_latched_q;
    assign core_halt_req_o = halt_req_q;
    assign core_npc_o     = npc_q;
    assign core_npc_we_o  = npc_we_q;
    assign rf_req_o       = rf_req_q;
    assign rf_we_o        = rf_we_q;
    assign rf_addr_o      = rf_addr_q;
    assign rf_wdata_o     = rf_wdata_q;

endmodule

// File: doc/adbg_core_dbg_unit.md
ADBG_CORE_DBG_UNIT -- requirements
Module: adbg_core_dbg_unit

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk_i, rst_i.
REQ-002 SHALL have ports (name dir width meaning), debug-bus responder side:
- clk_i in 1 clock
- rst_i in 1 sync reset, active-high
- dbg_addr_i in 16 word address
- dbg_data_i in 32 write data
- dbg_data_o out 32 read data
- dbg_stb_i in 1 request strobe, held until ack
- dbg_we_i in 1 1=write
- dbg_ack_o out 1 one-cycle completion pulse
- dbg_stall_i in 1 host halt request
- dbg_bp_o out 1 core stopped on its own (breakpoint/step)
REQ-003 SHALL have core-side ports:
- core_halt_req_o out 1 halt core
- core_halted_i in 1 core is halted
- core_trap_i in 1 one-cycle pulse, trap instruction executed
- core_retire_i in 1 one-cycle pulse, instruction retired
- core_pc_i in 32 current PC
- core_npc_o out 32 new PC
- core_npc_we_o out 1 one-cycle PC write pulse
- rf_req_o out 1 register-file request, held until rf_gnt_i
- rf_we_o out 1 register-file write
- rf_addr_o out 5 GPR index
- rf_wdata_o out 32 GPR write data
- rf_rdata_i in 32 GPR read data, valid with rf_gnt_i
- rf_gnt_i in 1 register-file grant

Function
REQ-004 Register map: 0x0000 CTRL (bit0 STEP, bit1 ERR sticky, W1C); 0x0001 CAUSE RO (0 none, 1 trap, 2 step, 3 host, 4 hw-bp); 0x0002 NPC (read core_pc_i, write pulses core_npc_we_o with core_npc_o=data); 0x0400-0x041F GPR window; other addresses SHALL read 0, ignore writes, still ack.
REQ-005 FSM states IDLE, DEC, RF, ACK, WAITLOW; IDLE->DEC on dbg_stb_i=1; DEC->ACK for non-GPR; DEC->RF for GPR with core_halted_i=1; RF->ACK on rf_gnt_i; ACK->WAITLOW; WAITLOW->IDLE when dbg_stb_i=0.
REQ-006 Non-GPR access: dbg_ack_o SHALL pulse exactly 2 cycles after first cycle stb sampled high; dbg_data_o valid in ack cycle, 0 otherwise.
REQ-007 GPR access: rf_req_o asserted from RF entry until rf_gnt_i; rf_addr_o=dbg_addr_i[4:0]; dbg_ack_o pulses the cycle after rf_gnt_i with captured rf_rdata_i (reads).
REQ-008 GPR access while core_halted_i=0 SHALL not assert rf_req_o, SHALL ack with data 0, SHALL set CTRL.ERR.
REQ-009 dbg_stb_i held high after ack SHALL NOT start a second transaction; one access per strobe.
REQ-010 bp_latched SHALL set on core_trap_i (CAUSE=1) or on core_retire_i with CTRL.STEP=1 (CAUSE=2), when dbg_stall_i=0.
REQ-011 bp_latched SHALL clear in any cycle dbg_stall_i=1; stall wins over simultaneous trap/step; CAUSE=3 on stall rising edge if bp_latched=0.
REQ-012 dbg_bp_o=bp_latched; core_halt_req_o=dbg_stall_i|bp_latched, registered (1-cycle latency).
REQ-013 Trap and retire in same cycle with STEP=1 SHALL record CAUSE=1.

Reset
REQ-014 rst_i=1 SHALL return FSM to IDLE, clear CTRL, CAUSE, bp_latched; all outputs 0 next cycle, including mid-transaction (no ack emitted).

Configuration
REQ-015 Macro ADBG_CORE_HW_BP_EN defined: register 0x0003 BPADDR RW, CTRL bit2 BPEN; core_pc_i==BPADDR with BPEN=1, core_halted_i=0, dbg_stall_i=0 sets bp_latched, CAUSE=4 (trap priority above hw-bp, hw-bp above step).
REQ-016 Macro undefined: 0x0003 reads 0, writes ignored, CTRL bit2 reads 0, no comparator logic.

Verification
REQ-017 Write 0x0002=0x1C000080 -> core_npc_we_o one pulse, core_npc_o=0x1C000080, dbg_ack_o 2 cycles after stb.
REQ-018 Core halted, read 0x0405, rf_gnt_i 3 cycles after rf_req_o, rf_rdata_i=0xDEADBEEF -> ack next cycle, dbg_data_o=0xDEADBEEF, rf_addr_o=5.
REQ-019 Core running, write 0x0401 -> no rf_req_o, ack, CTRL read = 0x2; write CTRL=0x2 -> read 0x0.
REQ-020 STEP=1, core_retire_i pulse -> dbg_bp_o=1, core_halt_req_o=1, CAUSE=2; dbg_stall_i=1 -> dbg_bp_o=0 next cycle.
REQ-021 core_trap_i and dbg_stall_i=1 same cycle -> dbg_bp_o stays 0; rst_i during RF state -> no ack, rf_req_o=0.
REQ-022 ADBG_CORE_HW_BP_EN: BPADDR=0x100, BPEN=1, core_pc_i=0x100 -> dbg_bp_o=1, CAUSE=4; undefined: BPADDR reads 0.
